// File: rtl/clefia_pkg.sv
// Shared definitions for the CLEFIA-128 key-schedule sequencer: states, step counts,
// CON index constants, and the per-state output decode.
package clefia_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_LGEN  = 3'd2,
    ST_RKGEN = 3'd3,
    ST_DONE  = 3'd4
  } ks_state_e;

  localparam int         NUM_LGEN    = 12;
  localparam int         NUM_RK_STEP = 18;
  localparam logic [4:0] CON_RK_BASE = 5'd12;
  localparam logic [4:0] CON_IDLE    = 5'h1F;

  localparam logic [4:0] LGEN_LAST = 5'(NUM_LGEN - 1);
  localparam logic [4:0] RK_LAST   = 5'(NUM_RK_STEP - 1);

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] con_idx;
    logic       lgen_load;
    logic       lgen_en;
    logic       rk_we;
    logic [5:0] rk_addr;
    logic       rk_xor_k;
    logic       sigma_en;
  } ks_out_t;

  // Outputs seen while sitting in state st with step counter cnt.
  // In RKGEN the iteration is i = cnt/2, so i[0] is cnt[1]; Sigma fires on odd steps.
  function automatic ks_out_t ks_decode(input ks_state_e st, input logic [4:0] cnt);
    ks_out_t o;
    o = '{busy: 1'b0, done: 1'b0, con_idx: CON_IDLE, lgen_load: 1'b0, lgen_en: 1'b0,
          rk_we: 1'b0, rk_addr: 6'd0, rk_xor_k: 1'b0, sigma_en: 1'b0};
    case (st)
      ST_LOAD: begin
        o.busy      = 1'b1;
        o.lgen_load = 1'b1;
      end
      ST_LGEN: begin
        o.busy    = 1'b1;
        o.lgen_en = 1'b1;
        o.con_idx = cnt;
      end
      ST_RKGEN: begin
        o.busy     = 1'b1;
        o.con_idx  = CON_RK_BASE + cnt;
        o.rk_we    = 1'b1;
        o.rk_addr  = {cnt, 1'b0};
        o.rk_xor_k = cnt[1];
        o.sigma_en = cnt[0];
      end
      ST_DONE: begin
        o.done = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/clefia_ks_seq_if.sv
// Control/strobe bundle between a key-schedule requester and clefia_ks_seq.
// abort is carried always; it only reaches the sequencer when CLEFIA_KS_ABORT_EN is defined.
interface clefia_ks_seq_if (input logic clk);
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [4:0] con_idx;
  logic       lgen_load;
  logic       lgen_en;
  logic       rk_we;
  logic [5:0] rk_addr;
  logic       rk_xor_k;
  logic       sigma_en;

  modport master (
    input  clk,
    output start, abort,
    input  busy, done, con_idx, lgen_load, lgen_en, rk_we, rk_addr, rk_xor_k, sigma_en
  );

  modport slave (
    input  clk,
    input  start, abort,
    output busy, done, con_idx, lgen_load, lgen_en, rk_we, rk_addr, rk_xor_k, sigma_en
  );
endinterface

// File: rtl/clefia_ks_seq.sv
// CLEFIA-128 key-schedule sequencer: LOAD, 12 GFN rounds, 18 round-key steps, DONE.
// Optional abort input enabled by defining CLEFIA_KS_ABORT_EN.
module clefia_ks_seq
  import clefia_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef CLEFIA_KS_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic [4:0] con_idx,
  output logic       lgen_load,
  output logic       lgen_en,
  output logic       rk_we,
  output logic [5:0] rk_addr,
  output logic       rk_xor_k,
  output logic       sigma_en
);

  ks_state_e  state_reg, state_next;
  logic [4:0] cnt_reg, cnt_next;
  ks_out_t    out_reg;
  logic       abort_w;

`ifdef CLEFIA_KS_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Counter clears on every state entry; abort outranks a terminal-count move.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = 5'd0;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_next = 5'd0;
        if (abort_w) state_next = ST_IDLE;
        else         state_next = ST_LGEN;
      end
      ST_LGEN: begin
        if (abort_w) begin
          state_next = ST_IDLE;
          cnt_next   = 5'd0;
        end else if (cnt_reg == LGEN_LAST) begin
          state_next = ST_RKGEN;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      ST_RKGEN: begin
        if (abort_w) begin
          state_next = ST_IDLE;
          cnt_next   = 5'd0;
        end else if (cnt_reg == RK_LAST) begin
          state_next = ST_DONE;
          cnt_next   = 5'd0;
        end else begin
          cnt_next = cnt_reg + 5'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = 5'd0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 5'd0;
      out_reg   <= ks_decode(ST_IDLE, 5'd0);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= ks_decode(state_next, cnt_next);
    end
  end

  assign busy      = out_reg.busy;
  assign done      = out_reg.done;
  assign con_idx   = out_reg.con_idx;
  assign lgen_load = out_reg.lgen_load;
  assign lgen_en   = out_reg.lgen_en;
  assign rk_we     = out_reg.rk_we;
  assign rk_addr   = out_reg.rk_addr;
  assign rk_xor_k  = out_reg.rk_xor_k;
  assign sigma_en  = out_reg.sigma_en;

endmodule

// File: tb/tb_clefia_ks_seq.sv
// Scoreboarded bench for clefia_ks_seq: per-cycle expected output vectors are queued
// from the run timeline and compared one clock after each edge.
module tb_clefia_ks_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clefia_ks_seq_if ifc (.clk(clk));

  clefia_ks_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (ifc.start),
`ifdef CLEFIA_KS_ABORT_EN
    .abort    (ifc.abort),
`endif
    .busy     (ifc.busy),
    .done     (ifc.done),
    .con_idx  (ifc.con_idx),
    .lgen_load(ifc.lgen_load),
    .lgen_en  (ifc.lgen_en),
    .rk_we    (ifc.rk_we),
    .rk_addr  (ifc.rk_addr),
    .rk_xor_k (ifc.rk_xor_k),
    .sigma_en (ifc.sigma_en)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [17:0] exp_q[$];

  int          done_seen;
  int          sigma_seen;
  logic [17:0] xor_mask;

  // Vector layout: busy done con[4:0] load en we addr[5:0] xor sigma.
  // k = cycles since the start-sampling edge (1..32); 0 means idle.
  function automatic logic [17:0] exp_vec(input int k);
    logic b, d, ld, en, we, xk, sg;
    logic [4:0] con;
    logic [5:0] addr;
    int s;
    b = 0; d = 0; ld = 0; en = 0; we = 0; xk = 0; sg = 0;
    con = 5'h1F; addr = 6'd0;
    if (k == 1) begin
      b = 1; ld = 1;
    end else if (k >= 2 && k <= 13) begin
      b = 1; en = 1; con = 5'(k - 2);
    end else if (k >= 14 && k <= 31) begin
      s = k - 14;
      b = 1; we = 1; con = 5'(12 + s); addr = 6'(2 * s);
      xk = ((s / 2) % 2) == 1; sg = (s % 2) == 1;
    end else if (k == 32) begin
      d = 1;
    end
    return {b, d, con, ld, en, we, addr, xk, sg};
  endfunction

  function automatic logic [17:0] act_vec();
    return {ifc.busy, ifc.done, ifc.con_idx, ifc.lgen_load, ifc.lgen_en, ifc.rk_we,
            ifc.rk_addr, ifc.rk_xor_k, ifc.sigma_en};
  endfunction

  task automatic push_run(input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back(exp_vec(k));
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(exp_vec(0));
  endtask

  task automatic clear_stats();
    done_seen = 0; sigma_seen = 0; xor_mask = '0;
  endtask

  task automatic tick(input string tag);
    logic [17:0] e, a;
    @(posedge clk); #1;
    cyc++;
    a = act_vec();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s cyc=%0d scoreboard empty actual=%h", tag, cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", tag, cyc, a, e);
      end
    end
    if (a[16] === 1'b1) done_seen++;
    if (a[8] === 1'b1 && a[0] === 1'b1) sigma_seen++;
    if (a[8] === 1'b1 && a[1] === 1'b1) xor_mask[a[7:3]] = 1'b1;
  endtask

  // One start pulse, full run, one trailing idle cycle.
  task automatic do_run(input string tag);
    clear_stats();
    ifc.start = 1'b1;
    push_run(1, 32);
    push_idle(1);
    tick(tag);
    ifc.start = 1'b0;
    for (int k = 0; k < 32; k++) tick(tag);
    checks++;
    if (done_seen !== 1) begin
      errors++;
      $display("FAIL %s_done_count actual=%0d required=1", tag, done_seen);
    end
    $display("run %s: done pulses=%0d", tag, done_seen);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push_idle(3);
    for (int k = 0; k < 3; k++) tick("reset");
    rst_n = 1'b1;
    push_idle(2);
    for (int k = 0; k < 2; k++) tick("reset_release");
    $display("reset: idle outputs checked");
  endtask

  task automatic test_nominal();
    do_run("nominal");
    checks++;
    if (sigma_seen !== 9) begin
      errors++;
      $display("FAIL sigma_count actual=%0d required=9", sigma_seen);
    end
    checks++;
    if (xor_mask !== 18'h0CCCC) begin
      errors++;
      $display("FAIL rk_xor_mask actual=%h required=%h", xor_mask, 18'h0CCCC);
    end
    $display("strobes: sigma=%0d xor_mask=%h", sigma_seen, xor_mask);
  endtask

  task automatic test_start_held();
    clear_stats();
    ifc.start = 1'b1;
    push_run(1, 32);
    push_idle(1);
    push_run(1, 32);
    push_idle(1);
    for (int k = 0; k < 34; k++) tick("start_held");
    ifc.start = 1'b0;
    for (int k = 0; k < 32; k++) tick("start_held");
    checks++;
    if (done_seen !== 2) begin
      errors++;
      $display("FAIL start_held_done_count actual=%0d required=2", done_seen);
    end
    $display("start_held: done pulses=%0d", done_seen);
  endtask

  task automatic test_reset_mid();
    clear_stats();
    ifc.start = 1'b1;
    push_run(1, 19);
    tick("reset_mid");
    ifc.start = 1'b0;
    for (int k = 0; k < 18; k++) tick("reset_mid");
    rst_n = 1'b0;
    push_idle(1);
    tick("reset_mid_hit");
    rst_n = 1'b1;
    push_idle(15);
    for (int k = 0; k < 15; k++) tick("reset_mid_after");
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_done_count actual=%0d required=0", done_seen);
    end
    $display("reset_mid: done pulses=%0d", done_seen);
    do_run("after_reset");
  endtask

`ifdef CLEFIA_KS_ABORT_EN
  task automatic test_abort();
    clear_stats();
    ifc.start = 1'b1;
    push_run(1, 31);
    tick("abort");
    ifc.start = 1'b0;
    for (int k = 0; k < 30; k++) tick("abort");
    ifc.abort = 1'b1;
    push_idle(1);
    tick("abort_hit");
    ifc.abort = 1'b0;
    push_idle(3);
    for (int k = 0; k < 3; k++) tick("abort_after");
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL abort_done_count actual=%0d required=0", done_seen);
    end
    ifc.abort = 1'b1;
    push_idle(4);
    for (int k = 0; k < 4; k++) tick("abort_idle");
    ifc.abort = 1'b0;
    $display("abort: done pulses=%0d", done_seen);
    do_run("after_abort");
  endtask
`endif

  task automatic test_idle();
    rst_n = 1'b0;
    push_idle(1);
    tick("idle_reset");
    rst_n = 1'b1;
    push_idle(100);
    for (int k = 0; k < 100; k++) tick("idle");
    $display("idle: 100 cycles checked");
  endtask

  initial begin
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    test_reset();
    test_nominal();
    test_start_held();
    test_reset_mid();
`ifdef CLEFIA_KS_ABORT_EN
    test_abort();
`endif
    test_idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
